// File: rtl/ulpi_pkg.sv
// Shared ULPI link constants: PID nibbles, TX CMD prefix, CRC16 parameters,
// transmit FSM state encodings and PID classification helpers.
package ulpi_pkg;

  localparam logic [7:0] TXCMD_PREFIX = 8'h40;

  // Handshake PIDs (low nibble)
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;

  // Data PIDs (low nibble)
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;

  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'hA001;

  // Transmit FSM state encodings
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_TURN   = 4'd1;
  localparam logic [3:0] ST_TXCMD  = 4'd2;
  localparam logic [3:0] ST_DATA   = 4'd3;
  localparam logic [3:0] ST_CRC_LO = 4'd4;
  localparam logic [3:0] ST_CRC_HI = 4'd5;
  localparam logic [3:0] ST_STOP   = 4'd6;
  localparam logic [3:0] ST_GAP    = 4'd7;
  localparam logic [3:0] ST_DRAIN  = 4'd8;

  // A PID byte carries its own check field: upper nibble is the complement of the lower.
  function automatic logic pid_ok(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

  function automatic logic pid_is_data(input logic [3:0] nib);
    return (nib == PID_DATA0) || (nib == PID_DATA1) ||
           (nib == PID_DATA2) || (nib == PID_MDATA);
  endfunction

endpackage

// File: rtl/ulpi_tx_encoder_if.sv
// ULPI transmit bus plus AXI-Stream packet source.
//   ulpi_dir_i / ulpi_nxt_i      : PHY bus ownership and byte-accept
//   ulpi_stp_o / ulpi_data_o / ulpi_oe_o : link drive side (tristate in parent)
//   s_tvalid_i / s_tready_o / s_tlast_i / s_tdata_i : packet in, first byte is PID
// master: the encoder; slave: PHY plus packet source.
interface ulpi_tx_encoder_if;
  logic       ulpi_dir_i;
  logic       ulpi_nxt_i;
  logic       ulpi_stp_o;
  logic [7:0] ulpi_data_o;
  logic       ulpi_oe_o;
  logic       s_tvalid_i;
  logic       s_tready_o;
  logic       s_tlast_i;
  logic [7:0] s_tdata_i;

  modport master (
    input  ulpi_dir_i, ulpi_nxt_i, s_tvalid_i, s_tlast_i, s_tdata_i,
    output ulpi_stp_o, ulpi_data_o, ulpi_oe_o, s_tready_o
  );

  modport slave (
    output ulpi_dir_i, ulpi_nxt_i, s_tvalid_i, s_tlast_i, s_tdata_i,
    input  ulpi_stp_o, ulpi_data_o, ulpi_oe_o, s_tready_o
  );
endinterface

// File: rtl/usb_crc16.sv
// USB CRC16 (reflected poly 0xA001), one byte per enabled cycle.
//   clock, areset_n : clock, async active-low reset (state -> 16'hFFFF)
//   clear           : synchronous reload of the initial value
//   enable, data    : fold one byte into the running CRC
//   crc             : current (uncomplemented) CRC state
module usb_crc16
  import ulpi_pkg::*;
(
  input  logic        clock,
  input  logic        areset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);
  logic [15:0] crc_q;
  logic [15:0] crc_next;

  always_comb begin
    crc_next = crc_q ^ {8'h00, data};
    for (int unsigned i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC16_POLY) : (crc_next >> 1);
    end
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n)   crc_q <= CRC16_INIT;
    else if (clear)  crc_q <= CRC16_INIT;
    else if (enable) crc_q <= crc_next;
  end

  assign crc = crc_q;
endmodule

// File: rtl/ulpi_tx_encoder.sv
// ULPI link transmit encoder: turns an AXI-Stream packet (PID first) into
// TX CMD, payload, CRC16 and STP on the ULPI bus.
//   clock, areset_n : 60 MHz ULPI clock, async active-low reset
//   bus             : ULPI drive side and AXI-S source (master modport)
//   busy_o          : packet in progress (any state but IDLE)
//   done_o          : one-cycle pulse with STP
//   abort_o         : one-cycle pulse on PHY bus grab or source underrun
//   pid_err_o       : one-cycle pulse on PID complement failure
module ulpi_tx_encoder
  import ulpi_pkg::*;
#(
  parameter bit HIGH_SPEED = 1'b1
) (
  input  logic              clock,
  input  logic              areset_n,
  ulpi_tx_encoder_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              abort_o,
  output logic              pid_err_o
);
  logic [3:0]  state_q, state_d;
  logic        dir_lo_q;
  logic        dir, nxt, ta_ok, drive_state;
  logic [15:0] crc, crc_tx;
  logic        crc_clear, crc_en;
  logic        stp_c, tready_c, done_c, abort_c, pid_err_c;
  logic [7:0]  data_c;

  assign dir    = bus.ulpi_dir_i;
  assign nxt    = bus.ulpi_nxt_i;
  // Turnaround: dir LO this cycle and the previous one.
  assign ta_ok  = !dir && dir_lo_q;
  assign crc_tx = ~crc;

  usb_crc16 u_crc (
    .clock    (clock),
    .areset_n (areset_n),
    .clear    (crc_clear),
    .enable   (crc_en),
    .data     (bus.s_tdata_i),
    .crc      (crc)
  );

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= ST_IDLE;
      dir_lo_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_lo_q <= !dir;
    end
  end

  always_comb begin
    state_d   = state_q;
    stp_c     = 1'b0;
    data_c    = '0;
    tready_c  = 1'b0;
    done_c    = 1'b0;
    abort_c   = 1'b0;
    pid_err_c = 1'b0;
    crc_clear = 1'b0;
    crc_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        crc_clear = 1'b1;
        if (!bus.s_tvalid_i)            state_d = ST_IDLE;
        else if (!ta_ok)                state_d = ST_TURN;
        else if (!pid_ok(bus.s_tdata_i)) begin
          pid_err_c = 1'b1;
          state_d   = ST_DRAIN;
        end else                        state_d = ST_TXCMD;
      end
      ST_TXCMD: begin
        data_c = TXCMD_PREFIX | {4'h0, bus.s_tdata_i[3:0]};
        // PID byte stays unconsumed on abort so the packet restarts from IDLE.
        if (dir) begin
          abort_c = 1'b1;
          state_d = ST_IDLE;
        end else if (nxt) begin
          tready_c = 1'b1;
          if (!pid_is_data(bus.s_tdata_i[3:0])) state_d = ST_STOP;
          else if (bus.s_tlast_i)               state_d = ST_CRC_LO;
          else                                  state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        data_c = bus.s_tdata_i;
        if (dir || !bus.s_tvalid_i) begin
          abort_c = 1'b1;
          state_d = ST_DRAIN;
        end else if (nxt) begin
          tready_c = 1'b1;
          crc_en   = 1'b1;
          if (bus.s_tlast_i) state_d = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        data_c = crc_tx[7:0];
        if (dir) begin
          abort_c = 1'b1;
          state_d = ST_IDLE;
        end else if (nxt) state_d = ST_CRC_HI;
      end
      ST_CRC_HI: begin
        data_c = crc_tx[15:8];
        if (dir) begin
          abort_c = 1'b1;
          state_d = ST_IDLE;
        end else if (nxt) state_d = ST_STOP;
      end
      ST_STOP: begin
        stp_c   = 1'b1;
        done_c  = 1'b1;
        state_d = HIGH_SPEED ? ST_IDLE : ST_GAP;
      end
      ST_GAP:   state_d = ST_IDLE;
      ST_DRAIN: begin
        tready_c = 1'b1;
        if (bus.s_tvalid_i && bus.s_tlast_i) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign drive_state = (state_q == ST_TXCMD)  || (state_q == ST_DATA) ||
                       (state_q == ST_CRC_LO) || (state_q == ST_CRC_HI) ||
                       (state_q == ST_STOP);

  // dir gates the drive combinationally so the link releases the bus the same cycle.
  assign bus.ulpi_oe_o   = drive_state && !dir;
  assign bus.ulpi_data_o = bus.ulpi_oe_o ? data_c : 8'h00;
  assign bus.ulpi_stp_o  = stp_c;
  assign bus.s_tready_o  = tready_c;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_c;
  assign abort_o         = abort_c;
  assign pid_err_o       = pid_err_c;
endmodule

// File: tb/tb_ulpi_tx_encoder.sv
`timescale 1ns/1ps
module tb_ulpi_tx_encoder;
  localparam bit HS = 1'b0;

  logic clock = 1'b0;
  logic areset_n = 1'b0;
  logic busy_o, done_o, abort_o, pid_err_o;

  ulpi_tx_encoder_if bus ();

  ulpi_tx_encoder #(.HIGH_SPEED(HS)) dut (
    .clock     (clock),
    .areset_n  (areset_n),
    .bus       (bus),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .abort_o   (abort_o),
    .pid_err_o (pid_err_o)
  );

  always #8 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] pkt   [16];
  logic [7:0] exp_b [16];
  logic [7:0] acc_q [$];
  int n_stp, n_done, n_abort, n_perr, n_hold_err, n_oe, n_oe_dir, n_stp_data, src_idx, gap_cycles;
  int nxt_mode;

  // Bit-serial reference CRC over pkt[first..last], returned complemented.
  function automatic logic [15:0] usb_crc(input int first, input int last);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = first; i <= last; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ pkt[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_oe"},     bus.ulpi_oe_o,   1'b0);
    check_val({tag, "_stp"},    bus.ulpi_stp_o,  1'b0);
    check_val({tag, "_data"},   bus.ulpi_data_o, 8'h00);
    check_val({tag, "_tready"}, bus.s_tready_o,  1'b0);
    check_val({tag, "_busy"},   busy_o,          1'b0);
    check_val({tag, "_pulses"}, {done_o, abort_o, pid_err_o}, 3'b000);
  endtask

  // Source + PHY model for one packet. dir_at/rst_at: accepted-byte count at
  // which to raise dir for one cycle / pulse reset (-1 = never).
  task automatic run_pkt(input int n, input int dir_at, input int rst_at);
    int k;
    logic dir_done, did_reset, stp_seen, p_oe, p_nxt, p_stp;
    logic [7:0] p_data;
    n_stp = 0; n_done = 0; n_abort = 0; n_perr = 0; n_hold_err = 0;
    n_oe = 0; n_oe_dir = 0; n_stp_data = 0; src_idx = 0; gap_cycles = 0;
    acc_q.delete();
    k = 0; dir_done = 1'b0; did_reset = 1'b0; stp_seen = 1'b0;
    p_oe = 1'b0; p_nxt = 1'b0; p_stp = 1'b0; p_data = 8'h00;
    @(posedge clock) #2;
    while (1) begin
      bus.s_tvalid_i = (src_idx < n);
      bus.s_tdata_i  = (src_idx < n) ? pkt[src_idx] : 8'h00;
      bus.s_tlast_i  = (src_idx == n - 1);
      bus.ulpi_nxt_i = (nxt_mode == 0) ? (k >= 1) : k[0];
      bus.ulpi_dir_i = 1'b0;
      if (dir_at >= 0 && !dir_done && acc_q.size() == dir_at) begin
        bus.ulpi_dir_i = 1'b1;
        dir_done = 1'b1;
      end
      if (rst_at >= 0 && acc_q.size() == rst_at) begin
        #2;
        check_val("pre_reset_oe", bus.ulpi_oe_o, 1'b1);
        areset_n = 1'b0;
        #1;
        check_quiet("async_reset");
        did_reset = 1'b1;
        break;
      end
      @(negedge clock);
      if (bus.ulpi_stp_o) begin
        n_stp++;
        stp_seen = 1'b1;
        if (bus.ulpi_data_o != 8'h00) n_stp_data++;
      end else if (stp_seen && busy_o) gap_cycles++;
      n_done  += int'(done_o);
      n_abort += int'(abort_o);
      n_perr  += int'(pid_err_o);
      if (bus.ulpi_oe_o) n_oe++;
      if (bus.ulpi_dir_i && bus.ulpi_oe_o) n_oe_dir++;
      if (p_oe && !p_nxt && !p_stp && bus.ulpi_oe_o && bus.ulpi_data_o != p_data) n_hold_err++;
      if (bus.ulpi_oe_o && bus.ulpi_nxt_i && !bus.ulpi_stp_o) acc_q.push_back(bus.ulpi_data_o);
      if (bus.s_tvalid_i && bus.s_tready_o) src_idx++;
      p_oe = bus.ulpi_oe_o; p_nxt = bus.ulpi_nxt_i; p_stp = bus.ulpi_stp_o; p_data = bus.ulpi_data_o;
      if (src_idx == n && !busy_o) break;
      k++;
      if (k > 300) begin
        check_val("timeout", 1'b1, 1'b0);
        break;
      end
      @(posedge clock) #2;
    end
    bus.s_tvalid_i = 1'b0;
    bus.s_tlast_i  = 1'b0;
    bus.s_tdata_i  = 8'h00;
    bus.ulpi_nxt_i = 1'b0;
    bus.ulpi_dir_i = 1'b0;
    if (did_reset) begin
      @(negedge clock);
      areset_n = 1'b1;
    end
  endtask

  task automatic expect_pkt(input string tag, input int n_exp, input int n_src,
                            input int e_stp, input int e_abort, input int e_perr);
    check_val({tag, "_nbytes"}, acc_q.size(), n_exp);
    for (int i = 0; i < n_exp && i < acc_q.size(); i++)
      check_val($sformatf("%s_byte%0d", tag, i), acc_q[i], exp_b[i]);
    check_val({tag, "_stp"},      n_stp,      e_stp);
    check_val({tag, "_done"},     n_done,     e_stp);
    check_val({tag, "_stp_data"}, n_stp_data, 0);
    check_val({tag, "_abort"},    n_abort,    e_abort);
    check_val({tag, "_pid_err"},  n_perr,     e_perr);
    check_val({tag, "_hold"},     n_hold_err, 0);
    check_val({tag, "_consumed"}, src_idx,    n_src);
  endtask

  initial begin
    logic [15:0] crc;
    bus.ulpi_dir_i = 1'b0;
    bus.ulpi_nxt_i = 1'b0;
    bus.s_tvalid_i = 1'b0;
    bus.s_tlast_i  = 1'b0;
    bus.s_tdata_i  = 8'h00;
    nxt_mode = 0;

    idle_cycles(3);
    @(negedge clock);
    check_quiet("reset");
    areset_n = 1'b1;
    idle_cycles(3);

    // ACK handshake
    pkt[0] = 8'hD2; exp_b[0] = 8'h42;
    nxt_mode = 0;
    run_pkt(1, -1, -1);
    expect_pkt("ack", 1, 1, 1, 0, 0);
    check_val("ack_gap", gap_cycles, HS ? 0 : 1);
    idle_cycles(3);

    // DATA1 zero-length packet
    pkt[0] = 8'h4B;
    exp_b[0] = 8'h4B; exp_b[1] = 8'h00; exp_b[2] = 8'h00;
    run_pkt(1, -1, -1);
    expect_pkt("zlp", 3, 1, 1, 0, 0);
    idle_cycles(3);

    // DATA0 + 4 payload bytes, nxt toggling
    pkt[0] = 8'hC3; pkt[1] = 8'h00; pkt[2] = 8'h01; pkt[3] = 8'h02; pkt[4] = 8'h03;
    crc = usb_crc(1, 4);
    exp_b[0] = 8'h43; exp_b[1] = 8'h00; exp_b[2] = 8'h01; exp_b[3] = 8'h02; exp_b[4] = 8'h03;
    exp_b[5] = crc[7:0]; exp_b[6] = crc[15:8];
    nxt_mode = 1;
    run_pkt(5, -1, -1);
    expect_pkt("data0", 7, 5, 1, 0, 0);
    idle_cycles(3);

    // dir grabs the bus while payload byte 2 is presented
    exp_b[0] = 8'h43; exp_b[1] = 8'h00;
    run_pkt(5, 2, -1);
    expect_pkt("abort", 2, 5, 0, 1, 0);
    check_val("abort_oe_with_dir", n_oe_dir, 0);
    idle_cycles(3);

    // packet after the abort goes out whole
    pkt[0] = 8'hD2; exp_b[0] = 8'h42;
    nxt_mode = 0;
    run_pkt(1, -1, -1);
    expect_pkt("ack_after_abort", 1, 1, 1, 0, 0);
    idle_cycles(3);

    // bad PID complement
    pkt[0] = 8'hD3; pkt[1] = 8'h00; pkt[2] = 8'h11;
    run_pkt(3, -1, -1);
    expect_pkt("bad_pid", 0, 3, 0, 0, 1);
    check_val("bad_pid_oe", n_oe, 0);
    idle_cycles(3);

    // async reset while CRC_LO is on the bus
    pkt[0] = 8'hC3; pkt[1] = 8'hAA; pkt[2] = 8'h55;
    nxt_mode = 1;
    run_pkt(3, -1, 3);
    check_val("reset_no_stp", n_stp, 0);
    idle_cycles(3);
    @(negedge clock);
    check_quiet("post_reset");

    pkt[0] = 8'hD2; exp_b[0] = 8'h42;
    nxt_mode = 0;
    run_pkt(1, -1, -1);
    expect_pkt("ack_after_reset", 1, 1, 1, 0, 0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ulpi_tx_encoder.md
ULPI_TX_ENCODER -- requirements
Module: ulpi_tx_encoder

Interface
REQ-001 Parameter HIGH_SPEED, 1, when 0 inserts one extra idle cycle after STP (FS inter-packet gap).
REQ-002 clock  in  1  60 MHz ULPI clock; all logic on rising edge.
REQ-003 areset_n  in  1  reset, asynchronous, active-low.
REQ-004 ulpi_dir_i  in  1  PHY owns bus when HI.
REQ-005 ulpi_nxt_i  in  1  PHY accepts current byte when HI.
REQ-006 ulpi_stp_o  out  1  end-of-packet strobe.
REQ-007 ulpi_data_o  out  8  byte driven to PHY.
REQ-008 ulpi_oe_o  out  1  link drives ulpi_data; tristate lives in parent.
REQ-009 s_tvalid_i / s_tready_o / s_tlast_i / s_tdata_i[7:0]  AXI-S packet in; first byte is PID.
REQ-010 busy_o  out  1  packet in progress; done_o, abort_o, pid_err_o  out  1  one-cycle pulses.

Function
REQ-011 States: IDLE, TURN, TXCMD, DATA, CRC_LO, CRC_HI, STOP, GAP, DRAIN.
REQ-012 IDLE: on s_tvalid_i with ulpi_dir_i LO for >=2 consecutive cycles (turnaround) -> TXCMD; else wait.
REQ-013 PID valid iff s_tdata_i[7:4]==~s_tdata_i[3:0]; invalid -> pid_err_o pulse, DRAIN.
REQ-014 TXCMD: ulpi_data_o=8'h40|PID[3:0], oe HI, held until ulpi_nxt_i HI; PID byte consumed (s_tready_o HI) in that cycle.
REQ-015 Handshake PIDs (low nibble 2,A,E,6) must carry s_tlast_i on PID byte; after nxt -> STOP, no CRC.
REQ-016 Data PIDs (low nibble 3,B,7,F): DATA presents s_tdata_i; byte advances only when ulpi_nxt_i HI (s_tready_o = nxt & state==DATA); last byte -> CRC_LO.
REQ-017 Data PID with s_tlast_i on PID byte = zero-length packet -> CRC_LO directly.
REQ-018 CRC16: reflected poly 0xA001, init 16'hFFFF over payload only, transmitted complemented, low byte in CRC_LO, high in CRC_HI, each held until nxt.
REQ-019 Source stall (s_tvalid_i LO in DATA) not permitted by USB timing: treat as underrun -> abort per REQ-021.
REQ-020 STOP: ulpi_stp_o=1, ulpi_data_o=8'h00 for exactly one cycle, done_o pulse, then GAP (if !HIGH_SPEED) or IDLE.
REQ-021 ulpi_dir_i HI in TXCMD..CRC_HI: oe LO same cycle (combinational), abort_o pulse, no STP, -> DRAIN if tlast not yet consumed else IDLE; TXCMD abort restarts packet later (PID byte not consumed).
REQ-022 DRAIN: s_tready_o HI, discard until tlast accepted, -> IDLE.
REQ-023 ulpi_oe_o HI only in TXCMD..STOP with ulpi_dir_i LO; ulpi_data_o=8'h00 otherwise.
REQ-024 busy_o HI in all states except IDLE.

Reset
REQ-025 areset_n LO: state IDLE, CRC=16'hFFFF, all outputs 0 (stp, oe, data, tready, pulses) immediately.
REQ-026 Reset mid-packet abandons packet without STP; no drain after release.

Structure
REQ-027 PID nibble constants and TX CMD prefix 8'h40 in shared package ulpi_pkg.
REQ-028 CRC16 byte-update in sub-module usb_crc16 (8-bit in, 16-bit state, clear, enable).
REQ-029 Target 150-300 lines RTL; no RAM.

Verification
REQ-030 ACK byte 8'hD2+tlast, dir LO, nxt HI after 1 cycle -> data 8'h42 then stp with 8'h00, done_o once.
REQ-031 DATA1 ZLP 8'h4B+tlast -> 8'h4B, 8'h00, 8'h00, stp; no payload bytes.
REQ-032 DATA0 PID + 4 bytes 00 01 02 03, nxt toggling 1-0-1 -> each byte held until nxt, CRC bytes match bench CRC16 model, total 7 nxt-accepted bytes.
REQ-033 dir HI during payload byte 2 -> oe LO same cycle, abort_o pulse, no stp, remaining bytes drained, next packet sent correctly.
REQ-034 PID 8'hD3 (bad complement) -> pid_err_o, packet discarded, bus untouched.
REQ-035 areset_n LO mid-CRC -> outputs 0 asynchronously; after release, new ACK packet sent correctly.
